// File: rtl/spi_command_receiver_if.sv
// Pin and hand-off bundle for spi_command_receiver: raw SPI pins plus the
// RX FIFO (valid/ready) and TX holding-register interfaces toward the core.
interface spi_command_receiver_if;
    logic       i_spi_cs_n;
    logic       i_spi_clk;
    logic       i_spi_mosi;
    logic       o_spi_miso;
    logic [7:0] o_rx_data;
    logic       o_rx_first;
    logic       o_rx_valid;
    logic       i_rx_ready;
    logic [7:0] i_tx_data;
    logic       i_tx_valid;
    logic       o_tx_ready;
    logic       o_cs_active;
    logic       o_rx_overflow;
    logic       o_tx_underrun;

    modport slave (
        input  i_spi_cs_n, i_spi_clk, i_spi_mosi, i_rx_ready, i_tx_data, i_tx_valid,
        output o_spi_miso, o_rx_data, o_rx_first, o_rx_valid, o_tx_ready,
               o_cs_active, o_rx_overflow, o_tx_underrun
    );

    modport master (
        output i_spi_cs_n, i_spi_clk, i_spi_mosi, i_rx_ready, i_tx_data, i_tx_valid,
        input  o_spi_miso, o_rx_data, o_rx_first, o_rx_valid, o_tx_ready,
               o_cs_active, o_rx_overflow, o_tx_underrun
    );
endinterface

// File: rtl/spi_command_receiver.sv
// SPI mode-0 slave front end: oversampled pins, MSB-first byte assembly into a
// small FWFT FIFO, and response bytes serialised onto MISO from a holding register.
module spi_command_receiver #(
    parameter int         FIFO_DEPTH = 4,
    parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
    input logic                    i_master_clk,
    input logic                    i_reset_n,
    spi_command_receiver_if.slave  bus
);
    localparam int AW = $clog2(FIFO_DEPTH);

    logic          cs_s1_q, cs_s2_q, cs_s3_q;
    logic          sclk_s1_q, sclk_s2_q, sclk_s3_q;
    logic          mosi_s1_q, mosi_s2_q;
    logic [1:0]    rst_dly_q;
    logic          armed_q;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          first_pend_q, first_pend_d;
    logic          overflow_q, overflow_d;
    logic          underrun_q, underrun_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic          miso_q, miso_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [8:0]    fifo_mem_q [FIFO_DEPTH];
    logic [8:0]    head;

    logic cs_act, cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic push_req, push_ok, pop, fifo_empty, fifo_full, load_req;

    // armed_q blocks a transaction already in flight at reset from being joined mid-byte
    assign cs_act    = armed_q & ~cs_s2_q;
    assign cs_fall   = armed_q &  cs_s3_q & ~cs_s2_q;
    assign cs_rise   = armed_q & ~cs_s3_q &  cs_s2_q;
    assign sclk_rise = cs_act  & ~sclk_s3_q &  sclk_s2_q;
    assign sclk_fall = cs_act  &  sclk_s3_q & ~sclk_s2_q;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = ~fifo_empty & bus.i_rx_ready;
    assign push_ok    = push_req & (~fifo_full | pop);
    assign head       = fifo_mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        first_pend_d = first_pend_q;
        overflow_d   = overflow_q;
        underrun_d   = 1'b0;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        tx_shift_d   = tx_shift_q;
        push_req     = 1'b0;
        load_req     = 1'b0;

        if (cs_fall) begin
            bit_cnt_d    = 3'd0;
            rx_shift_d   = 8'd0;
            first_pend_d = 1'b1;
            overflow_d   = 1'b0;
            load_req     = 1'b1;
        end else if (cs_rise) begin
            bit_cnt_d = 3'd0;
        end else if (sclk_rise) begin
            rx_shift_d = {rx_shift_q[6:0], mosi_s2_q};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                push_req     = 1'b1;
                first_pend_d = 1'b0;
            end
        end else if (sclk_fall) begin
            if (bit_cnt_q == 3'd0) load_req = 1'b1;
            else                   tx_shift_d = {tx_shift_q[6:0], 1'b1};
        end

        if (push_req && !push_ok) overflow_d = 1'b1;

        // a load sees the holding register as it was at the start of the cycle
        if (load_req) begin
            if (hold_full_q) begin
                tx_shift_d  = hold_q;
                hold_full_d = 1'b0;
            end else begin
                tx_shift_d  = FILL_BYTE;
                underrun_d  = 1'b1;
            end
        end
        if (bus.i_tx_valid && !hold_full_q) begin
            hold_d      = bus.i_tx_data;
            hold_full_d = 1'b1;
        end

        miso_d   = (armed_q & ~cs_s3_q) ? tx_shift_q[7] : 1'b1;
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_ok);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop);
    end

    always_ff @(posedge i_master_clk) begin
        if (!i_reset_n) begin
            {cs_s1_q, cs_s2_q, cs_s3_q}       <= 3'b111;
            {sclk_s1_q, sclk_s2_q, sclk_s3_q} <= 3'b000;
            {mosi_s1_q, mosi_s2_q}            <= 2'b00;
            rst_dly_q    <= 2'b00;
            armed_q      <= 1'b0;
            bit_cnt_q    <= 3'd0;
            rx_shift_q   <= 8'd0;
            first_pend_q <= 1'b0;
            overflow_q   <= 1'b0;
            underrun_q   <= 1'b0;
            hold_q       <= 8'd0;
            hold_full_q  <= 1'b0;
            tx_shift_q   <= FILL_BYTE;
            miso_q       <= 1'b1;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            {cs_s1_q, cs_s2_q, cs_s3_q}       <= {bus.i_spi_cs_n, cs_s1_q, cs_s2_q};
            {sclk_s1_q, sclk_s2_q, sclk_s3_q} <= {bus.i_spi_clk, sclk_s1_q, sclk_s2_q};
            {mosi_s1_q, mosi_s2_q}            <= {bus.i_spi_mosi, mosi_s1_q};
            rst_dly_q    <= {rst_dly_q[0], 1'b1};
            armed_q      <= armed_q | (rst_dly_q[1] & cs_s2_q);
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            first_pend_q <= first_pend_d;
            overflow_q   <= overflow_d;
            underrun_q   <= underrun_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            tx_shift_q   <= tx_shift_d;
            miso_q       <= miso_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_master_clk) begin
        if (push_ok) fifo_mem_q[wr_ptr_q[AW-1:0]] <= {first_pend_q, rx_shift_d};
    end

    assign bus.o_spi_miso    = miso_q;
    assign bus.o_rx_data     = fifo_empty ? 8'd0 : head[7:0];
    assign bus.o_rx_first    = ~fifo_empty & head[8];
    assign bus.o_rx_valid    = ~fifo_empty;
    assign bus.o_tx_ready    = ~hold_full_q;
    assign bus.o_cs_active   = cs_act;
    assign bus.o_rx_overflow = overflow_q;
    assign bus.o_tx_underrun = underrun_q;
endmodule

// File: tb/tb_spi_command_receiver.sv
// Bench for spi_command_receiver: SPI master at MASTER/8, byte-level reference
// model of the RX stream, MISO bytes and underrun strobes.
module tb_spi_command_receiver;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    spi_command_receiver_if bus ();

    spi_command_receiver #(.FIFO_DEPTH(4), .FILL_BYTE(8'hFF)) dut (
        .i_master_clk (clk),
        .i_reset_n    (rst_n),
        .bus          (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int consumer_mode = 0;   // 0 never ready, 1 always, 2 random, 3 driven by test
    int underruns = 0;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial forever begin
        @(negedge clk);
        if (bus.o_tx_underrun) underruns++;
        if (bus.o_rx_valid && bus.i_rx_ready) got_q.push_back({bus.o_rx_first, bus.o_rx_data});
    end

    initial begin
        bus.i_rx_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            case (consumer_mode)
                0: bus.i_rx_ready = 1'b0;
                1: bus.i_rx_ready = 1'b1;
                2: bus.i_rx_ready = ($urandom_range(3) != 0);
                default: ;
            endcase
        end
    end

    task automatic check_reset_vals(input string tag);
        check_eq({tag, " miso"},     bus.o_spi_miso, 1);
        check_eq({tag, " valid"},    bus.o_rx_valid, 0);
        check_eq({tag, " data"},     bus.o_rx_data, 0);
        check_eq({tag, " first"},    bus.o_rx_first, 0);
        check_eq({tag, " tx_ready"}, bus.o_tx_ready, 1);
        check_eq({tag, " cs_act"},   bus.o_cs_active, 0);
        check_eq({tag, " ovf"},      bus.o_rx_overflow, 0);
        check_eq({tag, " undr"},     bus.o_tx_underrun, 0);
    endtask

    task automatic cs_begin();
        bus.i_spi_cs_n = 1'b0;
        step(6);
    endtask

    task automatic cs_end();
        if (bus.i_spi_clk) begin
            bus.i_spi_clk = 1'b0;
            step(4);
        end
        bus.i_spi_cs_n = 1'b1;
        step(6);
    endtask

    // each bit: falling edge (if clock high), low phase, sample MISO, rising edge, high phase
    task automatic spi_bits(input logic [7:0] mo, input int nbits, input bit sync_pop,
                            output logic [7:0] mi);
        mi = 8'd0;
        for (int i = 0; i < nbits; i++) begin
            if (bus.i_spi_clk) bus.i_spi_clk = 1'b0;
            bus.i_spi_mosi = mo[7-i];
            step(4);
            mi = {mi[6:0], bus.o_spi_miso};
            bus.i_spi_clk = 1'b1;
            if (sync_pop && i == nbits - 1) begin
                step(2);
                bus.i_rx_ready = 1'b1;
                step(1);
                bus.i_rx_ready = 1'b0;
                step(1);
            end else begin
                step(4);
            end
        end
    endtask

    task automatic offer_tx(input logic [7:0] b);
        int t = 0;
        bus.i_tx_data  = b;
        bus.i_tx_valid = 1'b1;
        while (!bus.o_tx_ready && t < 500) begin
            step(1);
            t++;
        end
        check_eq("offer_tx ready", bus.o_tx_ready, 1);
        step(1);
        bus.i_tx_valid = 1'b0;
    endtask

    task automatic drain_check(input string tag);
        int t = 0;
        while (got_q.size() < exp_q.size() && t < 2000) begin
            step(1);
            t++;
        end
        step(2);
        check_eq({tag, " count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check_eq($sformatf("%s[%0d]", tag, i), got_q[i], exp_q[i]);
        check_eq({tag, " empty"}, bus.o_rx_valid, 0);
        exp_q.delete();
        got_q.delete();
    endtask

    initial begin
        logic [7:0] mi, b;
        logic [7:0] bytes_q[$];
        int n;
        bit pre;
        logic [7:0] p;

        rst_n = 1'b0;
        bus.i_spi_cs_n = 1'b1;
        bus.i_spi_clk  = 1'b0;
        bus.i_spi_mosi = 1'b0;
        bus.i_tx_data  = 8'd0;
        bus.i_tx_valid = 1'b0;
        step(3);
        check_reset_vals("reset");
        rst_n = 1'b1;
        step(5);

        // two bytes, consumer always ready
        consumer_mode = 1;
        cs_begin();
        spi_bits(8'hA5, 8, 0, mi);
        spi_bits(8'h3C, 8, 0, mi);
        cs_end();
        exp_q.push_back({1'b1, 8'hA5});
        exp_q.push_back({1'b0, 8'h3C});
        check_eq("basic ovf", bus.o_rx_overflow, 0);
        drain_check("basic");

        // preload 0x81, offer 0x42 during byte 0, three bytes clocked
        offer_tx(8'h81);
        check_eq("preload tx_ready", bus.o_tx_ready, 0);
        underruns = 0;
        cs_begin();
        bytes_q.delete();
        for (int i = 0; i < 3; i++) bytes_q.push_back(8'($urandom));
        fork
            begin step(20); offer_tx(8'h42); end
            spi_bits(bytes_q[0], 8, 0, mi);
        join
        check_eq("tx miso0", mi, 8'h81);
        spi_bits(bytes_q[1], 8, 0, mi);
        check_eq("tx miso1", mi, 8'h42);
        check_eq("tx undr before load3", underruns, 0);
        spi_bits(bytes_q[2], 8, 0, mi);
        check_eq("tx miso2", mi, 8'hFF);
        check_eq("tx undr after load3", underruns, 1);
        cs_end();
        for (int i = 0; i < 3; i++) exp_q.push_back({i == 0, bytes_q[i]});
        drain_check("tx rx");

        // overflow: six bytes into a four-entry FIFO with no consumer
        consumer_mode = 0;
        cs_begin();
        for (int i = 0; i < 6; i++) begin
            b = 8'($urandom);
            spi_bits(b, 8, 0, mi);
            if (i < 4) exp_q.push_back({i == 0, b});
        end
        cs_end();
        check_eq("ovf sticky", bus.o_rx_overflow, 1);
        consumer_mode = 1;
        drain_check("ovf");
        cs_begin();
        check_eq("ovf cleared by cs", bus.o_rx_overflow, 0);
        cs_end();

        // partial byte aborted by CS, then 0x7E
        cs_begin();
        spi_bits(8'($urandom), 5, 0, mi);
        cs_end();
        cs_begin();
        spi_bits(8'h7E, 8, 0, mi);
        cs_end();
        exp_q.push_back({1'b1, 8'h7E});
        drain_check("partial");

        // full FIFO with push and pop in the same cycle
        consumer_mode = 3;
        bus.i_rx_ready = 1'b0;
        step(2);
        cs_begin();
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom);
            exp_q.push_back({i == 0, b});
            spi_bits(b, 8, i == 4, mi);
        end
        check_eq("sim pop count", got_q.size(), 1);
        check_eq("sim ovf", bus.o_rx_overflow, 0);
        check_eq("sim valid", bus.o_rx_valid, 1);
        cs_end();
        consumer_mode = 1;
        drain_check("sim");

        // one-cycle reset mid-byte with CS held low
        cs_begin();
        spi_bits(8'($urandom), 4, 0, mi);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        check_reset_vals("midrst");
        spi_bits(8'($urandom), 4, 0, mi);
        spi_bits(8'($urandom), 8, 0, mi);
        check_eq("midrst no push", got_q.size(), 0);
        check_eq("midrst cs_act", bus.o_cs_active, 0);
        check_eq("midrst miso", bus.o_spi_miso, 1);
        cs_end();
        b = 8'($urandom);
        cs_begin();
        spi_bits(b, 8, 0, mi);
        cs_end();
        exp_q.push_back({1'b1, b});
        drain_check("midrst");

        // random transactions with a random consumer and optional preload
        consumer_mode = 2;
        for (int t = 0; t < 6; t++) begin
            n   = $urandom_range(1, 3);
            pre = 1'($urandom);
            p   = 8'($urandom);
            underruns = 0;
            if (pre) offer_tx(p);
            cs_begin();
            for (int i = 0; i < n; i++) begin
                b = 8'($urandom);
                exp_q.push_back({i == 0, b});
                spi_bits(b, 8, 0, mi);
                check_eq($sformatf("rnd%0d miso%0d", t, i), mi, (i == 0 && pre) ? p : 8'hFF);
            end
            cs_end();
            check_eq($sformatf("rnd%0d undr", t), underruns, n + 1 - (pre ? 1 : 0));
            check_eq($sformatf("rnd%0d ovf", t), bus.o_rx_overflow, 0);
            drain_check($sformatf("rnd%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
